// File: rtl/wb_conmax_pri_arb.sv
// Per-slave 8-master arbiter. Qualifies requests against the encoder's active
// priority level, picks round-robin among them, and holds the grant until release.
module wb_conmax_pri_arb #(
  parameter logic [1:0]  pri_sel  = 2'd0,
  parameter int unsigned HOLD_MAX = 0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] req,
  input  logic [1:0] pri0,
  input  logic [1:0] pri1,
  input  logic [1:0] pri2,
  input  logic [1:0] pri3,
  input  logic [1:0] pri4,
  input  logic [1:0] pri5,
  input  logic [1:0] pri6,
  input  logic [1:0] pri7,
  input  logic [1:0] pri_in,
  input  logic       next,
  output logic [2:0] gnt,
  output logic       gnt_vld,
  output logic [7:0] gnt_oh
);

  localparam int unsigned NM       = 8;
  localparam int unsigned IW       = 3;
  localparam int unsigned CW       = 8;
  localparam int unsigned HOLD_LIM = (HOLD_MAX == 0) ? 0 : HOLD_MAX - 1;
  localparam bit          HOLD_EN  = (HOLD_MAX != 0);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   last, last_nxt;
  logic [IW-1:0]   gnt_nxt;
  logic            vld_nxt;
  logic [NM-1:0]   oh_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [1:0]      pri_arr [NM];
  logic [NM-1:0]   elig;
  logic [NM-1:0]   gnt_mask;
  logic            others;
  logic            hold_hit;

  // Map a master's priority field onto the encoder's level space.
  function automatic logic [1:0] map_lvl(input logic [1:0] p);
    case (pri_sel)
      2'd0:    map_lvl = 2'd0;
      2'd1:    map_lvl = {1'b0, p[0]};
      default: map_lvl = p;
    endcase
  endfunction

  // First candidate at ptr+1, ptr+2, ... wrapping; ptr itself is scanned last.
  function automatic logic [IW-1:0] rr_pick(input logic [NM-1:0] cand,
                                            input logic [IW-1:0] ptr);
    logic [IW-1:0] idx;
    logic          found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int k = 1; k <= int'(NM); k++) begin
      idx = IW'(int'(ptr) + k);
      if (!found && cand[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  always_comb begin
    pri_arr[0] = pri0;
    pri_arr[1] = pri1;
    pri_arr[2] = pri2;
    pri_arr[3] = pri3;
    pri_arr[4] = pri4;
    pri_arr[5] = pri5;
    pri_arr[6] = pri6;
    pri_arr[7] = pri7;
  end

  always_comb begin
    elig = '0;
    for (int i = 0; i < int'(NM); i++) begin
      elig[i] = req[i] & (map_lvl(pri_arr[i]) == pri_in);
    end
  end

  assign gnt_mask = NM'(1) << gnt;
  assign others   = |(elig & ~gnt_mask);
  assign hold_hit = HOLD_EN && (cnt == CW'(HOLD_LIM));

  // Next-state and next-output logic.
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    vld_nxt   = gnt_vld;
    last_nxt  = last;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        vld_nxt = 1'b0;
        if (|elig) begin
          gnt_nxt   = rr_pick(elig, last);
          vld_nxt   = 1'b1;
          last_nxt  = gnt_nxt;
          cnt_nxt   = '0;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (!req[gnt] || (others && (next || hold_hit))) begin
          cnt_nxt = '0;
          if (others) begin
            gnt_nxt  = rr_pick(elig & ~gnt_mask, gnt);
            last_nxt = gnt_nxt;
          end else begin
            vld_nxt   = 1'b0;
            state_nxt = IDLE;
          end
        end else if (HOLD_EN && !hold_hit) begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
    oh_nxt = vld_nxt ? (NM'(1) << gnt_nxt) : '0;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      gnt     <= '0;
      gnt_vld <= 1'b0;
      gnt_oh  <= '0;
      last    <= IW'(NM - 1);
      cnt     <= '0;
    end else begin
      state   <= state_nxt;
      gnt     <= gnt_nxt;
      gnt_vld <= vld_nxt;
      gnt_oh  <= oh_nxt;
      last    <= last_nxt;
      cnt     <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_wb_conmax_pri_arb.sv
// Directed bench for wb_conmax_pri_arb: three instances cover single-level,
// two-level and four-level/hold-limited configurations.
module tb_wb_conmax_pri_arb;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [7:0] req;
  logic [1:0] p0, p1, p2, p3, p4, p5, p6, p7;
  logic [1:0] pri_in;
  logic       next;

  logic [2:0] ga, gb, gc;
  logic       va, vb, vc;
  logic [7:0] oha, ohb, ohc;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  wb_conmax_pri_arb #(.pri_sel(2'd0), .HOLD_MAX(0)) u_a (
    .clk_i(clk_i), .rst_i(rst_i), .req(req),
    .pri0(p0), .pri1(p1), .pri2(p2), .pri3(p3),
    .pri4(p4), .pri5(p5), .pri6(p6), .pri7(p7),
    .pri_in(pri_in), .next(next),
    .gnt(ga), .gnt_vld(va), .gnt_oh(oha));

  wb_conmax_pri_arb #(.pri_sel(2'd1), .HOLD_MAX(0)) u_b (
    .clk_i(clk_i), .rst_i(rst_i), .req(req),
    .pri0(p0), .pri1(p1), .pri2(p2), .pri3(p3),
    .pri4(p4), .pri5(p5), .pri6(p6), .pri7(p7),
    .pri_in(pri_in), .next(next),
    .gnt(gb), .gnt_vld(vb), .gnt_oh(ohb));

  wb_conmax_pri_arb #(.pri_sel(2'd2), .HOLD_MAX(4)) u_c (
    .clk_i(clk_i), .rst_i(rst_i), .req(req),
    .pri0(p0), .pri1(p1), .pri2(p2), .pri3(p3),
    .pri4(p4), .pri5(p5), .pri6(p6), .pri7(p7),
    .pri_in(pri_in), .next(next),
    .gnt(gc), .gnt_vld(vc), .gnt_oh(ohc));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    req    = '0;
    next   = 1'b0;
    pri_in = 2'd0;
    {p0, p1, p2, p3, p4, p5, p6, p7} = '0;
    rst_i  = 1'b0;
    tick();
    rst_i  = 1'b1;
  endtask

  initial begin
    logic [2:0] exp_seq [9];

    // Reset state of all instances
    do_reset();
    chk("rst_gnt_a", 8'(ga), 8'd0);
    chk("rst_vld_a", 8'(va), 8'd0);
    chk("rst_oh_a", oha, 8'h00);
    chk("rst_vld_b", 8'(vb), 8'd0);
    chk("rst_vld_c", 8'(vc), 8'd0);
    chk("rst_oh_c", ohc, 8'h00);

    // 1: single requester, one-cycle latency, drop returns to idle
    req = 8'h01;
    #1;
    chk("t1_no_comb_grant", 8'(va), 8'd0);
    tick();
    chk("t1_gnt", 8'(ga), 8'd0);
    chk("t1_vld", 8'(va), 8'd1);
    chk("t1_oh", oha, 8'h01);
    req = 8'h00;
    tick();
    chk("t1_drop_vld", 8'(va), 8'd0);
    chk("t1_drop_oh", oha, 8'h00);
    chk("t1_drop_gnt_hold", 8'(ga), 8'd0);

    // 2: two requesters, next every cycle alternates with no gap
    do_reset();
    req = 8'h05;
    tick();
    chk("t2_g0", 8'(ga), 8'd0);
    next = 1'b1;
    tick();
    chk("t2_g1", 8'(ga), 8'd2);
    chk("t2_v1", 8'(va), 8'd1);
    chk("t2_oh1", oha, 8'h04);
    tick();
    chk("t2_g2", 8'(ga), 8'd0);
    chk("t2_v2", 8'(va), 8'd1);
    tick();
    chk("t2_g3", 8'(ga), 8'd2);
    next = 1'b0;
    tick();
    chk("t2_hold", 8'(ga), 8'd2);
    chk("t2_hold_vld", 8'(va), 8'd1);

    // 3: four-level qualification, then release to lower level on drop
    do_reset();
    p1 = 2'd1;
    p3 = 2'd3;
    pri_in = 2'd3;
    req = 8'h0A;
    tick();
    chk("t3_gnt3", 8'(gc), 8'd3);
    chk("t3_oh3", ohc, 8'h08);
    req = 8'h02;
    pri_in = 2'd1;
    tick();
    chk("t3_gnt1", 8'(gc), 8'd1);
    chk("t3_vld1", 8'(vc), 8'd1);
    chk("t3_oh1", ohc, 8'h02);

    // 4: two-level mode, lower-level master never granted
    do_reset();
    p0 = 2'b10;
    p4 = 2'b01;
    pri_in = 2'd1;
    req = 8'h11;
    tick();
    chk("t4_gnt4", 8'(gb), 8'd4);
    chk("t4_oh4", ohb, 8'h10);
    next = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t4_keep4", 8'(gb), 8'd4);
    end
    next = 1'b0;

    // 5: tenure limit of 4 cycles rotates between two requesters
    do_reset();
    exp_seq = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd1, 3'd0};
    req = 8'h03;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk($sformatf("t5_seq%0d", i), 8'(gc), 8'(exp_seq[i]));
      chk($sformatf("t5_vld%0d", i), 8'(vc), 8'd1);
      if (i == 7) chk("t5_nolimit_a", 8'(ga), 8'd0);
    end
    req = 8'h01;
    for (int i = 0; i < 6; i++) tick();
    chk("t5_single_gnt", 8'(gc), 8'd0);
    chk("t5_single_vld", 8'(vc), 8'd1);

    // 6: async reset mid-grant, restart from master 0
    do_reset();
    req = 8'h20;
    tick();
    chk("t6_gnt5", 8'(gc), 8'd5);
    chk("t6_vld5", 8'(vc), 8'd1);
    #1;
    rst_i = 1'b0;
    #1;
    chk("t6_async_gnt", 8'(gc), 8'd0);
    chk("t6_async_vld", 8'(vc), 8'd0);
    chk("t6_async_oh", ohc, 8'h00);
    req = 8'hFF;
    #2;
    rst_i = 1'b1;
    tick();
    chk("t6_restart_gnt", 8'(gc), 8'd0);
    chk("t6_restart_a", 8'(ga), 8'd0);
    next = 1'b1;
    tick();
    chk("t6_next_gnt", 8'(gc), 8'd1);
    chk("t6_next_oh", ohc, 8'h02);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
